// File: rtl/tpc_pattern_source_if.sv
// PIO, fpc0 and tpc0 signal bundle for tpc_pattern_source.
// master drives PIO/fpc/tpc_ready; slave is the pattern source.
interface tpc_pattern_source_if;
    logic        pio_write_valid;
    logic [12:0] pio_address;
    logic [63:0] pio_write_data;
    logic [63:0] fpc_data;
    logic        fpc_empty;
    logic        fpc_read;
    logic [63:0] tpc_data;
    logic        tpc_write;
    logic        tpc_ready;

    modport master (
        output pio_write_valid, pio_address, pio_write_data,
        output fpc_data, fpc_empty, tpc_ready,
        input  fpc_read, tpc_data, tpc_write
    );

    modport slave (
        input  pio_write_valid, pio_address, pio_write_data,
        input  fpc_data, fpc_empty, tpc_ready,
        output fpc_read, tpc_data, tpc_write
    );
endinterface

// File: rtl/tpc_pattern_source.sv
// Counter / LFSR / fpc0-loopback source for the tpc0 write port.
// Optional loopback sequence checker: TPC_PATTERN_SOURCE_ERRCHK_EN.
module tpc_pattern_source #(
    parameter int ADDR_BASE = 16,
    parameter int CNT_W     = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    tpc_pattern_source_if.slave  bus,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     words_sent
`ifdef TPC_PATTERN_SOURCE_ERRCHK_EN
    ,
    output logic [31:0]          err_count
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [12:0] A_CTRL  = 13'(ADDR_BASE);
    localparam logic [12:0] A_COUNT = 13'(ADDR_BASE + 1);
    localparam logic [12:0] A_SEED  = 13'(ADDR_BASE + 2);

    state_t state, state_n;

    logic [1:0]       mode_q, run_mode;
    logic [CNT_W-1:0] count_q, run_count;
    logic [63:0]      seed_q, gen, gen_next;
    logic             wr_ctrl, wr_count, wr_seed;
    logic             start_req, stop_req, start;
    logic             lb, issue, last;

    assign wr_ctrl  = bus.pio_write_valid && (bus.pio_address == A_CTRL);
    assign wr_count = bus.pio_write_valid && (bus.pio_address == A_COUNT);
    assign wr_seed  = bus.pio_write_valid && (bus.pio_address == A_SEED);

    // stop wins over a simultaneous start
    assign start_req = wr_ctrl && bus.pio_write_data[8] && !bus.pio_write_data[9];
    assign stop_req  = wr_ctrl && bus.pio_write_data[9];
    assign start     = start_req && (state == IDLE);

    assign lb    = (run_mode == 2'd2);
    assign issue = (state == RUN) && bus.tpc_ready && (!lb || !bus.fpc_empty);
    assign last  = (run_count != '0) && ((words_sent + CNT_W'(1)) == run_count);

    assign bus.fpc_read = issue && lb;

    assign gen_next = (run_mode == 2'd1)
                    ? {gen[62:0], gen[63] ^ gen[62] ^ gen[60] ^ gen[59]}
                    : gen + 64'd1;

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (stop_req || (issue && last)) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q        <= '0;
            count_q       <= '0;
            seed_q        <= '0;
            run_mode      <= '0;
            run_count     <= '0;
            gen           <= '0;
            words_sent    <= '0;
            bus.tpc_data  <= '0;
            bus.tpc_write <= 1'b0;
        end else begin
            if (wr_ctrl)  mode_q  <= bus.pio_write_data[1:0];
            if (wr_count) count_q <= bus.pio_write_data[CNT_W-1:0];
            if (wr_seed)  seed_q  <= bus.pio_write_data;
            bus.tpc_write <= issue;
            if (start) begin
                run_mode   <= bus.pio_write_data[1:0];
                run_count  <= count_q;
                words_sent <= '0;
                // an all-zero LFSR would lock up
                if (bus.pio_write_data[1:0] == 2'd1 && seed_q == '0)
                    gen <= 64'd1;
                else
                    gen <= seed_q;
            end else if (issue) begin
                bus.tpc_data <= lb ? bus.fpc_data : gen;
                if (!lb) gen <= gen_next;
                if (words_sent != '1) words_sent <= words_sent + CNT_W'(1);
            end
        end
    end

`ifdef TPC_PATTERN_SOURCE_ERRCHK_EN
    logic        have_first;
    logic [63:0] prev_word;

    always_ff @(posedge clock) begin
        if (reset) begin
            err_count  <= '0;
            have_first <= 1'b0;
            prev_word  <= '0;
        end else if (start) begin
            err_count  <= '0;
            have_first <= 1'b0;
        end else if (bus.fpc_read) begin
            have_first <= 1'b1;
            prev_word  <= bus.fpc_data;
            if (have_first && bus.fpc_data != prev_word + 64'd1
                && err_count != 32'hFFFF_FFFF)
                err_count <= err_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tpc_pattern_source.sv
// Scoreboard bench for tpc_pattern_source: model words queued at start,
// a negedge monitor pops and compares every tpc write.
module tb_tpc_pattern_source;

    localparam int AB = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        busy, done;
    logic [31:0] words_sent;
`ifdef TPC_PATTERN_SOURCE_ERRCHK_EN
    logic [31:0] err_count;
`endif

    always #5 clock = ~clock;

    tpc_pattern_source_if dif();

    tpc_pattern_source #(.ADDR_BASE(AB), .CNT_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (dif),
        .busy       (busy),
        .done       (done),
        .words_sent (words_sent)
`ifdef TPC_PATTERN_SOURCE_ERRCHK_EN
        ,
        .err_count  (err_count)
`endif
    );

    int checks = 0;
    int errors = 0;
    int rx_cnt = 0;
    int done_cnt = 0;
    int rx0, d0;
    int ready_mode = 0;
    bit ready_tog = 1'b0;
    logic [63:0] scb[$];
    logic [63:0] fifo[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] lfsr(input logic [63:0] x);
        return {x[62:0], x[63] ^ x[62] ^ x[60] ^ x[59]};
    endfunction

    // monitor: every tpc write must match the head of the scoreboard
    always @(negedge clock) begin
        if (!reset) begin
            if (dif.tpc_write) begin
                rx_cnt++;
                if (scb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%0h required=none",
                             dif.tpc_data);
                end else begin
                    check("tpc_data", dif.tpc_data, scb.pop_front());
                end
            end
            if (done) done_cnt++;
            if (dif.fpc_read) check("fpc_read_when_empty", dif.fpc_empty, 0);
        end
    end

    task automatic drive_fpc();
        dif.fpc_empty = (fifo.size() == 0);
        dif.fpc_data  = (fifo.size() != 0) ? fifo[0] : 64'h0;
    endtask

    task automatic cycle();
        bit pop;
        @(negedge clock);
        pop = dif.fpc_read;
        @(posedge clock);
        #1;
        if (pop && fifo.size() != 0) void'(fifo.pop_front());
        drive_fpc();
        case (ready_mode)
            0: dif.tpc_ready = 1'b1;
            1: begin ready_tog = !ready_tog; dif.tpc_ready = ready_tog; end
            default: dif.tpc_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic pio(input int a, input logic [63:0] d);
        dif.pio_write_valid = 1'b1;
        dif.pio_address     = 13'(a);
        dif.pio_write_data  = d;
        cycle();
        dif.pio_write_valid = 1'b0;
    endtask

    task automatic push_model(input logic [1:0] mode, input int count,
                              input logic [63:0] seed);
        logic [63:0] x;
        x = (mode == 2'd1 && seed == 64'h0) ? 64'h1 : seed;
        for (int k = 0; k < count; k++) begin
            if (mode == 2'd1) begin
                scb.push_back(x);
                x = lfsr(x);
            end else begin
                scb.push_back(seed + 64'(k));
            end
        end
    endtask

    task automatic start_run(input logic [1:0] mode, input int count,
                             input logic [63:0] seed);
        rx0 = rx_cnt;
        d0  = done_cnt;
        pio(AB + 1, 64'(count));
        pio(AB + 2, seed);
        pio(AB, 64'(mode) | 64'h100);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = done;
        for (int i = 0; i < budget && !ok; i++) begin
            cycle();
            ok = done;
        end
    endtask

    task automatic finish_run(input string name, input int count);
        bit ok;
        wait_done(400, ok);
        check({name, "_done_seen"}, 64'(ok), 1);
        cycle();
        cycle();
        check({name, "_busy"}, busy, 0);
        check({name, "_words_sent"}, words_sent, count);
        check({name, "_write_count"}, rx_cnt - rx0, count);
        check({name, "_done_pulses"}, done_cnt - d0, 1);
        check({name, "_scb_empty"}, scb.size(), 0);
        scb.delete();
    endtask

    initial begin
        logic [63:0] seed;
        logic [63:0] w;
        logic [1:0]  m;
        int n, rx1;
        bit ok;

        dif.pio_write_valid = 1'b0;
        dif.pio_address     = '0;
        dif.pio_write_data  = '0;
        dif.tpc_ready       = 1'b1;
        drive_fpc();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        check("rst_tpc_write", dif.tpc_write, 0);
        check("rst_tpc_data", dif.tpc_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_words_sent", words_sent, 0);
        check("rst_fpc_read", dif.fpc_read, 0);

        // counter, ready held high
        ready_mode = 0;
        push_model(2'd0, 4, 64'h100);
        start_run(2'd0, 4, 64'h100);
        check("start_busy", busy, 1);
        check("start_no_write_yet", dif.tpc_write, 0);
        finish_run("cnt", 4);

        // counter with toggling backpressure
        ready_mode = 1;
        push_model(2'd0, 4, 64'h100);
        start_run(2'd0, 4, 64'h100);
        finish_run("bp", 4);

        // LFSR from a zero seed
        ready_mode = 0;
        push_model(2'd1, 3, 64'h0);
        check("lfsr_first_is_1", scb[0], 64'h1);
        start_run(2'd1, 3, 64'h0);
        finish_run("lfsr", 3);

        // loopback with a late second word
        fifo.push_back(64'hA);
        drive_fpc();
        scb.push_back(64'hA);
        scb.push_back(64'hB);
        scb.push_back(64'hC);
        start_run(2'd2, 3, 64'h0);
        repeat (6) cycle();
        check("lb_stalled", rx_cnt - rx0, 1);
        fifo.push_back(64'hB);
        fifo.push_back(64'hC);
        drive_fpc();
        finish_run("lb", 3);

        // continuous run, stopped after 1000 cycles
        ready_mode = 2;
        seed = {$urandom, $urandom};
        push_model(2'd0, 2000, seed);
        start_run(2'd0, 0, seed);
        repeat (1000) cycle();
        pio(AB, 64'h200);
        wait_done(10, ok);
        check("cont_done_seen", 64'(ok), 1);
        cycle();
        cycle();
        check("cont_words_sent", words_sent, rx_cnt - rx0);
        check("cont_done_pulses", done_cnt - d0, 1);
        rx1 = rx_cnt;
        repeat (10) cycle();
        check("cont_no_writes_after_stop", rx_cnt, rx1);
        check("cont_busy", busy, 0);
        scb.delete();

        // start+stop together stays idle
        d0 = done_cnt;
        pio(AB, 64'h300);
        check("startstop_busy", busy, 0);
        cycle();
        check("startstop_busy2", busy, 0);
        check("startstop_no_done", done_cnt - d0, 0);
        check("startstop_no_write", rx_cnt, rx1);

        // reset in the middle of a COUNT=10 run
        ready_mode = 0;
        seed = {$urandom, $urandom};
        push_model(2'd0, 10, seed);
        start_run(2'd0, 10, seed);
        for (int i = 0; i < 50 && (rx_cnt - rx0) < 2; i++) cycle();
        check("rst_run_reached", 64'((rx_cnt - rx0) >= 2), 1);
        reset = 1'b1;
        cycle();
        check("midrst_tpc_write", dif.tpc_write, 0);
        check("midrst_busy", busy, 0);
        check("midrst_words_sent", words_sent, 0);
        check("midrst_done", done, 0);
        reset = 1'b0;
        cycle();
        cycle();
        check("midrst_no_done_pulse", done_cnt - d0, 0);
        scb.delete();

        // randomized runs in all modes
        for (int r = 0; r < 8; r++) begin
            m = 2'($urandom_range(0, 3));
            n = int'($urandom_range(1, 12));
            seed = {$urandom, $urandom};
            ready_mode = 2;
            if (m == 2'd2) begin
                for (int k = 0; k < n; k++) begin
                    w = {$urandom, $urandom};
                    fifo.push_back(w);
                    scb.push_back(w);
                end
                drive_fpc();
            end else begin
                push_model(m, n, seed);
            end
            start_run(m, n, seed);
            finish_run("rand", n);
            fifo.delete();
            drive_fpc();
        end

`ifdef TPC_PATTERN_SOURCE_ERRCHK_EN
        ready_mode = 0;
        fifo.push_back(64'd5);
        fifo.push_back(64'd6);
        fifo.push_back(64'd8);
        drive_fpc();
        scb.push_back(64'd5);
        scb.push_back(64'd6);
        scb.push_back(64'd8);
        start_run(2'd2, 3, 64'h0);
        check("errchk_cleared", err_count, 0);
        finish_run("errchk", 3);
        check("errchk_count", err_count, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
